// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the two-pass 32-bit ALU sequencer.
// Select codes are split by mode because the same code means different ops.
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_e;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  // arithmetic mode, no carry term
  localparam logic [3:0] SEL_PASS_A   = 4'b0000;
  localparam logic [3:0] SEL_AR_OR    = 4'b0001;
  localparam logic [3:0] SEL_AR_ORN   = 4'b0010;
  localparam logic [3:0] SEL_AR_ONES  = 4'b0011;
  localparam logic [3:0] SEL_AR_ANDN  = 4'b0100;
  // arithmetic mode, carry/borrow chained
  localparam logic [3:0] SEL_INC      = 4'b0101;
  localparam logic [3:0] SEL_SUB      = 4'b0110;
  localparam logic [3:0] SEL_DEC      = 4'b0111;
  localparam logic [3:0] SEL_ADD_AND  = 4'b1000;
  localparam logic [3:0] SEL_ADD      = 4'b1001;
  localparam logic [3:0] SEL_ADD_MIX  = 4'b1010;
  localparam logic [3:0] SEL_RSUB     = 4'b1011;
  localparam logic [3:0] SEL_DBL      = 4'b1100;
  localparam logic [3:0] SEL_ADD_OR   = 4'b1101;
  localparam logic [3:0] SEL_ADD_ORN  = 4'b1110;
  localparam logic [3:0] SEL_ADD_NOT  = 4'b1111;

  // logic mode
  localparam logic [3:0] SEL_NOT_A    = 4'b0000;
  localparam logic [3:0] SEL_NOR      = 4'b0001;
  localparam logic [3:0] SEL_NA_AND_B = 4'b0010;
  localparam logic [3:0] SEL_ZERO     = 4'b0011;
  localparam logic [3:0] SEL_NAND     = 4'b0100;
  localparam logic [3:0] SEL_NOT_B    = 4'b0101;
  localparam logic [3:0] SEL_XOR      = 4'b0110;
  localparam logic [3:0] SEL_A_AND_NB = 4'b0111;
  localparam logic [3:0] SEL_NA_OR_B  = 4'b1000;
  localparam logic [3:0] SEL_XNOR     = 4'b1001;
  localparam logic [3:0] SEL_PASS_B   = 4'b1010;
  localparam logic [3:0] SEL_AND      = 4'b1011;
  localparam logic [3:0] SEL_ONES     = 4'b1100;
  localparam logic [3:0] SEL_A_OR_NB  = 4'b1101;
  localparam logic [3:0] SEL_OR       = 4'b1110;
  localparam logic [3:0] SEL_L_PASS_A = 4'b1111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [3:0]  sel;
    logic        cin;
    logic        half;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for the ALU sequencer.
// master drives commands and accepts results; slave is the sequencer.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_mode;
  logic [3:0]  req_select;
  logic        req_carry_in;
  logic        req_half;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_mode,
    output req_select, req_carry_in, req_half,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result,
    input  rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode,
    input  req_select, req_carry_in, req_half,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result,
    output rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu16_core.sv
// 16-bit combinational ALU slice; carry ops use a 17-bit sum so that
// bit 16 is carry for adds and borrow for subtracts.
module alu16_core (
  input  logic        mode_i,
  input  logic [3:0]  sel_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] res_o,
  output logic        cout_o
);
  import alu_op_sequencer_pkg::*;

  logic [16:0] a17, b17, c17, sum;
  logic        use_sum;

  assign a17 = {1'b0, a_i};
  assign b17 = {1'b0, b_i};
  assign c17 = {16'd0, cin_i};

  // function table; only carry ops touch cout
  always_comb begin
    res_o   = 16'd0;
    cout_o  = 1'b0;
    sum     = 17'd0;
    use_sum = 1'b0;
    if (mode_i == MODE_LOGIC) begin
      unique case (sel_i)
        SEL_NOT_A:    res_o = ~a_i;
        SEL_NOR:      res_o = ~(a_i | b_i);
        SEL_NA_AND_B: res_o = ~a_i & b_i;
        SEL_ZERO:     res_o = 16'd0;
        SEL_NAND:     res_o = ~(a_i & b_i);
        SEL_NOT_B:    res_o = ~b_i;
        SEL_XOR:      res_o = a_i ^ b_i;
        SEL_A_AND_NB: res_o = a_i & ~b_i;
        SEL_NA_OR_B:  res_o = ~a_i | b_i;
        SEL_XNOR:     res_o = ~(a_i ^ b_i);
        SEL_PASS_B:   res_o = b_i;
        SEL_AND:      res_o = a_i & b_i;
        SEL_ONES:     res_o = 16'hFFFF;
        SEL_A_OR_NB:  res_o = a_i | ~b_i;
        SEL_OR:       res_o = a_i | b_i;
        SEL_L_PASS_A: res_o = a_i;
      endcase
    end else begin
      use_sum = 1'b1;
      unique case (sel_i)
        SEL_PASS_A:  begin res_o = a_i; use_sum = 1'b0; end
        SEL_AR_OR:   begin res_o = a_i | b_i; use_sum = 1'b0; end
        SEL_AR_ORN:  begin res_o = a_i | ~b_i; use_sum = 1'b0; end
        SEL_AR_ONES: begin res_o = 16'hFFFF; use_sum = 1'b0; end
        SEL_AR_ANDN: begin res_o = a_i & ~b_i; use_sum = 1'b0; end
        SEL_INC:     sum = a17 + c17;
        SEL_SUB:     sum = a17 - b17 - c17;
        SEL_DEC:     sum = a17 - c17;
        SEL_ADD_AND: sum = a17 + {1'b0, a_i & b_i} + c17;
        SEL_ADD:     sum = a17 + b17 + c17;
        SEL_ADD_MIX: sum = {1'b0, a_i | ~b_i} + {1'b0, a_i & b_i} + c17;
        SEL_RSUB:    sum = b17 - a17 - c17;
        SEL_DBL:     sum = a17 + a17 + c17;
        SEL_ADD_OR:  sum = {1'b0, a_i | b_i} + a17 + c17;
        SEL_ADD_ORN: sum = {1'b0, a_i | ~b_i} + a17 + c17;
        SEL_ADD_NOT: sum = a17 + {1'b0, ~b_i} + c17;
      endcase
      if (use_sum) begin
        res_o  = sum[15:0];
        cout_o = sum[16];
      end
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// 32-bit ALU built from one 16-bit slice used twice (low half, then high).
// Response fields are copied into output registers one cycle into DONE.
module alu_op_sequencer (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);
  import alu_op_sequencer_pkg::*;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [31:0] res_q, res_d;
  logic        cy_q, cy_d;
  logic        vld_q, vld_d;
  logic [31:0] out_q, out_d;
  logic        ocy_q, ocy_d;
  logic        oz_q, oz_d;

  logic [15:0] alu_a, alu_b, alu_res;
  logic        alu_cin, alu_cout;

  alu16_core u_alu (
    .mode_i (cmd_q.mode),
    .sel_i  (cmd_q.sel),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .cin_i  (alu_cin),
    .res_o  (alu_res),
    .cout_o (alu_cout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state, ALU operand steering and datapath updates
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    cy_d    = cy_q;
    vld_d   = vld_q;
    out_d   = out_q;
    ocy_d   = ocy_q;
    oz_d    = oz_q;
    alu_a   = cmd_q.a[15:0];
    alu_b   = cmd_q.b[15:0];
    alu_cin = cmd_q.cin;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cmd_d.a    = bus.req_a;
          cmd_d.b    = bus.req_b;
          cmd_d.mode = bus.req_mode;
          cmd_d.sel  = bus.req_select;
          cmd_d.cin  = bus.req_carry_in;
          cmd_d.half = bus.req_half;
          res_d      = 32'd0;
          cy_d       = 1'b0;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        res_d   = {16'd0, alu_res};
        cy_d    = alu_cout;
        state_d = cmd_q.half ? ST_DONE : ST_HI;
      end
      ST_HI: begin
        alu_a   = cmd_q.a[31:16];
        alu_b   = cmd_q.b[31:16];
        alu_cin = (cmd_q.mode == MODE_ARITH) && cy_q;
        res_d   = {alu_res, res_q[15:0]};
        cy_d    = alu_cout;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!vld_q) begin
          vld_d = 1'b1;
          out_d = res_q;
          ocy_d = cy_q;
          oz_d  = (res_q == 32'd0);
        end else if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // captured command, partial result and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      res_q <= 32'd0;
      cy_q  <= 1'b0;
      vld_q <= 1'b0;
      out_q <= 32'd0;
      ocy_q <= 1'b0;
      oz_q  <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      res_q <= res_d;
      cy_q  <= cy_d;
      vld_q <= vld_d;
      out_q <= out_d;
      ocy_q <= ocy_d;
      oz_q  <= oz_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_result = out_q;
  assign bus.rsp_carry  = ocy_q;
  assign bus.rsp_zero   = oz_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed corner cases plus random commands
// compared against a whole-word arithmetic reference model.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // whole-operand reference: {carry, result}
  function automatic logic [32:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic mode,
                                        input logic [3:0] sel,
                                        input logic cin,
                                        input logic half);
    logic [63:0] m, x, y, nx, ny, c, s, r;
    logic        co;
    int          w;
    w  = half ? 16 : 32;
    m  = (64'd1 << w) - 64'd1;
    x  = {32'd0, a} & m;
    y  = {32'd0, b} & m;
    nx = ~x & m;
    ny = ~y & m;
    c  = {63'd0, cin};
    s  = 64'd0;
    r  = 64'd0;
    co = 1'b0;
    if (mode) begin
      case (sel)
        4'd0:  r = nx;
        4'd1:  r = ~(x | y);
        4'd2:  r = nx & y;
        4'd3:  r = 64'd0;
        4'd4:  r = ~(x & y);
        4'd5:  r = ny;
        4'd6:  r = x ^ y;
        4'd7:  r = x & ny;
        4'd8:  r = nx | y;
        4'd9:  r = ~(x ^ y);
        4'd10: r = y;
        4'd11: r = x & y;
        4'd12: r = m;
        4'd13: r = x | ny;
        4'd14: r = x | y;
        default: r = x;
      endcase
    end else if (sel <= 4'd4) begin
      case (sel)
        4'd0: r = x;
        4'd1: r = x | y;
        4'd2: r = x | ny;
        4'd3: r = m;
        default: r = x & ny;
      endcase
    end else begin
      case (sel)
        4'd5:  s = x + c;
        4'd6:  s = x - y - c;
        4'd7:  s = x - c;
        4'd8:  s = x + (x & y) + c;
        4'd9:  s = x + y + c;
        4'd10: s = (x | ny) + (x & y) + c;
        4'd11: s = y - x - c;
        4'd12: s = x + x + c;
        4'd13: s = (x | y) + x + c;
        4'd14: s = (x | ny) + x + c;
        default: s = x + ny + c;
      endcase
      r  = s;
      co = s[w];
    end
    r = r & m;
    return {co, r[31:0]};
  endfunction

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b,
                           input logic mode, input logic [3:0] sel,
                           input logic cin, input logic half);
    bus.req_valid    = 1'b1;
    bus.req_a        = a;
    bus.req_b        = b;
    bus.req_mode     = mode;
    bus.req_select   = sel;
    bus.req_carry_in = cin;
    bus.req_half     = half;
  endtask

  // issue one command, check latency/result, hold for stall cycles, release
  task automatic run_cmd(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic mode,
                         input logic [3:0] sel, input logic cin,
                         input logic half, input logic [32:0] exp,
                         input int stall);
    int k;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ":rdy"}, {63'd0, bus.req_ready}, 64'd1);
    drive_cmd(a, b, mode, sel, cin, half);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ":lat"}, 64'(k), half ? 64'd2 : 64'd3);
    chk({tag, ":res"}, {32'd0, bus.rsp_result}, {32'd0, exp[31:0]});
    chk({tag, ":cy"}, {63'd0, bus.rsp_carry}, {63'd0, exp[32]});
    chk({tag, ":z"}, {63'd0, bus.rsp_zero},
        {63'd0, exp[31:0] == 32'd0});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, ":hold"},
          {29'd0, bus.rsp_valid, bus.req_ready, bus.rsp_carry,
           bus.rsp_result},
          {29'd0, 1'b1, 1'b0, exp});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ":rel"}, {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  sel;
    logic        mode, cin, half;
    logic [32:0] e;
    bit          seen;
    int          k;

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    drive_cmd(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    bus.req_valid = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    chk("reset", {29'd0, bus.req_ready, bus.rsp_valid, bus.rsp_carry,
                  bus.rsp_zero, bus.rsp_result},
        {29'd0, 4'b1000, 32'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("add_lo_cy", 32'h0000FFFF, 32'h1, MODE_ARITH, SEL_ADD,
            1'b0, 1'b0, {1'b0, 32'h00010000}, 0);
    run_cmd("add_wrap", 32'hFFFFFFFF, 32'h1, MODE_ARITH, SEL_ADD,
            1'b0, 1'b0, {1'b1, 32'h00000000}, 1);
    run_cmd("sub_chain", 32'h00010000, 32'h1, MODE_ARITH, SEL_SUB,
            1'b0, 1'b0, {1'b0, 32'h0000FFFF}, 0);
    run_cmd("xor_same", 32'h12345678, 32'h12345678, MODE_LOGIC, SEL_XOR,
            1'b0, 1'b0, {1'b0, 32'h0}, 0);
    run_cmd("xor_half", 32'h12345678, 32'h12345678, MODE_LOGIC, SEL_XOR,
            1'b0, 1'b1, {1'b0, 32'h0}, 0);
    run_cmd("add_half", 32'h1234FFFF, 32'h00000001, MODE_ARITH, SEL_ADD,
            1'b0, 1'b1, {1'b1, 32'h0}, 0);
    run_cmd("sub_half", 32'hABCD0000, 32'h00000001, MODE_ARITH, SEL_SUB,
            1'b0, 1'b1, {1'b1, 32'h0000FFFF}, 0);
    run_cmd("add_cin", 32'hFFFFFFFF, 32'h0, MODE_ARITH, SEL_ADD,
            1'b1, 1'b0, {1'b1, 32'h0}, 0);
    run_cmd("sub_borrow", 32'h0, 32'h0, MODE_ARITH, SEL_SUB,
            1'b1, 1'b0, {1'b1, 32'hFFFFFFFF}, 0);

    for (int n = 0; n < 40; n++) begin
      a    = $urandom;
      b    = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) b = 32'h0000FFFF;
      mode = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      cin  = 1'($urandom_range(0, 1));
      half = ($urandom_range(0, 3) == 0);
      e    = model(a, b, mode, sel, cin, half);
      run_cmd($sformatf("rnd%0d", n), a, b, mode, sel, cin, half, e,
              int'($urandom_range(0, 2)));
    end

    // backpressure with a competing command held on the request side
    e = model(32'h0F0F1234, 32'h00FF4321, MODE_ARITH, SEL_ADD, 1'b0, 1'b0);
    drive_cmd(32'h0F0F1234, 32'h00FF4321, MODE_ARITH, SEL_ADD, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_cmd(32'h11111111, 32'h22222222, MODE_LOGIC, SEL_OR, 1'b0, 1'b1);
    k = 0;
    while (!bus.rsp_valid && k < 8) begin
      @(posedge clk); #1; k++;
    end
    chk("bp:lat", 64'(k), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp:hold", {29'd0, bus.rsp_valid, bus.req_ready, bus.rsp_carry,
                      bus.rsp_result}, {29'd0, 1'b1, 1'b0, e});
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp:rel", {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid || !bus.req_ready) seen = 1'b1;
    end
    chk("bp:noqueue", {63'd0, seen}, 64'd0);

    // reset while the high half is in flight
    drive_cmd(32'hFFFFFFFF, 32'h1, MODE_ARITH, SEL_ADD, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_hi", {29'd0, bus.req_ready, bus.rsp_valid, bus.rsp_carry,
                   bus.rsp_zero, bus.rsp_result},
        {29'd0, 4'b1000, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {63'd0, bus.req_ready}, 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst_norsp", {63'd0, seen}, 64'd0);

    run_cmd("post_rst", 32'h00000005, 32'h00000003, MODE_ARITH, SEL_SUB,
            1'b0, 1'b0, {1'b0, 32'h00000002}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
